// File: rtl/full_adder_nbit_pkg.sv
// Shared constants for the ripple-carry adder family.
// Other blocks import this package to pick up the default adder width.
package full_adder_nbit_pkg;

    localparam int ADDER_DEFAULT_W = 16;

endpackage : full_adder_nbit_pkg

// File: rtl/full_adder_1b.sv
// Single-bit full adder: the leaf cell of the ripple chain.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    // Generate on a&b, otherwise propagate the incoming carry when exactly one input is set.
    assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder_1b

// File: rtl/full_adder_nbit.sv
// N-bit unsigned ripple-carry adder with a combinational result and a
// one-cycle registered copy for pipelined consumers.
module full_adder_nbit
    import full_adder_nbit_pkg::*;
#(
    parameter int N_W = ADDER_DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N_W-1:0] a,
    input  logic [N_W-1:0] b,
    output logic [N_W-1:0] sum,
    output logic           carry,
    output logic [N_W-1:0] sum_q,
    output logic           carry_q
);

    // c[i] is the carry into stage i; c[N_W] is the carry-out.
    logic [N_W:0] c;

    assign c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N_W; gi++) begin : g_stage
            full_adder_1b u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (c[gi]),
                .s    (sum[gi]),
                .cout (c[gi+1])
            );
        end
    endgenerate

    assign carry = c[N_W];

    // Reset only clears the registered copy; the combinational path ignores it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum;
            carry_q <= carry;
        end
    end

endmodule : full_adder_nbit

// File: tb/tb_full_adder_nbit.sv
// Directed and sweep checks of full_adder_nbit at widths 16, 8 and 1.
module tb_full_adder_nbit;

    logic        clk;
    logic        rst_n;

    logic [15:0] a16, b16, sum16, sum16_q;
    logic        carry16, carry16_q;
    logic [7:0]  a8, b8, sum8, sum8_q;
    logic        carry8, carry8_q;
    logic [0:0]  a1, b1, sum1, sum1_q;
    logic        carry1, carry1_q;

    int checks = 0;
    int errors = 0;

    full_adder_nbit #(.N_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16),
        .sum(sum16), .carry(carry16), .sum_q(sum16_q), .carry_q(carry16_q)
    );

    full_adder_nbit #(.N_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8),
        .sum(sum8), .carry(carry8), .sum_q(sum8_q), .carry_q(carry8_q)
    );

    full_adder_nbit #(.N_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
        .sum(sum1), .carry(carry1), .sum_q(sum1_q), .carry_q(carry1_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed 16-bit transaction: combinational check, then registered check after one edge.
    task automatic vec16(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] exp_sum, input logic exp_carry);
        @(negedge clk);
        a16 = va;
        b16 = vb;
        #1;
        check({tag, " sum"},   64'(sum16),   64'(exp_sum));
        check({tag, " carry"}, 64'(carry16), 64'(exp_carry));
        tick();
        check({tag, " sum_q"},   64'(sum16_q),   64'(exp_sum));
        check({tag, " carry_q"}, 64'(carry16_q), 64'(exp_carry));
        $display("vec %s: a=0x%04h b=0x%04h -> carry=%0d sum=0x%04h", tag, va, vb, carry16, sum16);
    endtask

    initial begin
        int err_start;
        logic [16:0] exp17;
        logic [8:0]  exp9;
        logic [1:0]  exp2;

        rst_n = 1'b0;
        a16 = 16'h0; b16 = 16'h0;
        a8  = 8'h0;  b8  = 8'h0;
        a1  = 1'b0;  b1  = 1'b0;

        // Reset is asynchronous: outputs clear before any clock edge.
        #2;
        check("reset sum_q",   64'(sum16_q),   64'h0);
        check("reset carry_q", 64'(carry16_q), 64'h0);
        check("reset sum8_q",  64'(sum8_q),    64'h0);
        $display("reset: sum_q=0x%04h carry_q=%0d", sum16_q, carry16_q);

        // Reset held across an edge must keep the register cleared.
        a16 = 16'hFFFF; b16 = 16'h0001;
        tick();
        check("reset held sum_q",   64'(sum16_q),   64'h0);
        check("reset held carry_q", 64'(carry16_q), 64'h0);

        // First edge after release captures the current a+b.
        @(negedge clk);
        rst_n = 1'b1;
        a16 = 16'h00FF; b16 = 16'h0F01;
        tick();
        check("post-release sum_q",   64'(sum16_q),   64'h1000);
        check("post-release carry_q", 64'(carry16_q), 64'h0);
        $display("release: sum_q=0x%04h carry_q=%0d", sum16_q, carry16_q);

        vec16("zero",      16'h0000, 16'h0000, 16'h0000, 1'b0);
        vec16("max",       16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
        vec16("prop ones", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        vec16("prop msb",  16'h8000, 16'h8000, 16'h0000, 1'b1);
        vec16("plain",     16'h1234, 16'h4321, 16'h5555, 1'b0);
        vec16("mixed",     16'hA5A5, 16'h5A5B, 16'h0000, 1'b1);
        vec16("no carry",  16'h7FFF, 16'h8000, 16'hFFFF, 1'b0);

        // Reset in the middle of operation: registered path clears, combinational path holds.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h4321;
        tick();
        check("mid sum_q before", 64'(sum16_q), 64'h5555);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset sum_q",   64'(sum16_q),   64'h0);
        check("mid reset carry_q", 64'(carry16_q), 64'h0);
        check("mid reset sum",     64'(sum16),     64'h5555);
        check("mid reset carry",   64'(carry16),   64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid release sum_q", 64'(sum16_q), 64'h5555);
        $display("mid-reset: sum_q=0x%04h after release", sum16_q);

        // Random sweep at 16 bits; stop at the first mismatch.
        err_start = errors;
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom_range(0, 16'hFFFF));
            b16 = 16'($urandom_range(0, 16'hFFFF));
            exp17 = {1'b0, a16} + {1'b0, b16};
            #5;
            check("random16", 64'({carry16, sum16}), 64'(exp17));
            if (errors != err_start) break;
        end
        $display("random16 sweep done: errors=%0d", errors - err_start);

        // Exhaustive 8-bit sweep.
        err_start = errors;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                a8 = i[7:0];
                b8 = j[7:0];
                exp9 = 9'(i + j);
                #1;
                check("exh8", 64'({carry8, sum8}), 64'(exp9));
                if (errors != err_start) break;
            end
            if (errors != err_start) break;
        end
        $display("exh8 sweep done: errors=%0d", errors - err_start);

        // Exhaustive 1-bit sweep, including the registered copy.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                a1 = i[0:0];
                b1 = j[0:0];
                exp2 = 2'(i + j);
                #1;
                check("exh1", 64'({carry1, sum1}), 64'(exp2));
                tick();
                check("exh1 q", 64'({carry1_q, sum1_q}), 64'(exp2));
                $display("vec n1: a=%0d b=%0d -> carry=%0d sum=%0d", a1, b1, carry1, sum1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_full_adder_nbit
